// File: rtl/mux_uart.sv
// Memory-mapped 8N1 serial port: status at BASE_ADDR, data at BASE_ADDR+1, combinational reads.
// Define MUX_UART_RXFIFO_EN for an RX_FIFO_DEPTH-entry receive FIFO instead of a single holding register.
module mux_uart #(
    parameter logic [15:0] BASE_ADDR     = 16'hF200,
    parameter int          CLKS_PER_BIT  = 16,
    parameter int          RX_FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        write_en,
    input  logic        read_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        sel,
    output logic        txd,
    input  logic        rxd,
    output logic [1:0]  o_dbg_tx_state,
    output logic [2:0]  o_dbg_rx_state
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 ||
        RX_FIFO_DEPTH < 1 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_cfg_check
        $error("mux_uart: unsupported CLKS_PER_BIT or RX_FIFO_DEPTH");
    end

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

    logic w_sel_stat, w_sel_data, w_wr_data, w_rd_stat, w_rd_data;
    logic [7:0] w_status, w_rx_head;
    logic w_rx_avail, w_pop, w_push, w_ovr_set, w_ferr_set;
    logic r_ovr, r_ferr;

    assign w_sel_stat = (address == BASE_ADDR);
    assign w_sel_data = (address == 16'(BASE_ADDR + 16'd1));
    assign sel        = w_sel_stat | w_sel_data;
    assign w_wr_data  = write_en & w_sel_data;
    // A write in the same cycle suppresses any read side effect.
    assign w_rd_stat  = read_en & w_sel_stat & ~write_en;
    assign w_rd_data  = read_en & w_sel_data & ~write_en;

    // ---------------- transmit ----------------
    tx_state_t r_tx_state, w_tx_state_nx;
    logic [TW-1:0] r_tx_timer, w_tx_timer_nx;
    logic [2:0] r_tx_bit, w_tx_bit_nx;
    logic [7:0] r_tx_shift, w_tx_shift_nx, r_tx_hold;
    logic r_txd, w_txd_nx, r_tx_full, w_tx_load;

    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_timer_nx = r_tx_timer;
        w_tx_bit_nx   = r_tx_bit;
        w_tx_shift_nx = r_tx_shift;
        w_txd_nx      = r_txd;
        w_tx_load     = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_timer_nx = '0;
                w_txd_nx      = 1'b1;
                w_tx_load     = r_tx_full;
            end
            TX_START: begin
                if (r_tx_timer == BIT_LAST) begin
                    w_tx_timer_nx = '0;
                    w_tx_bit_nx   = '0;
                    w_tx_state_nx = TX_DATA;
                    w_txd_nx      = r_tx_shift[0];
                end else begin
                    w_tx_timer_nx = r_tx_timer + TW'(1);
                end
            end
            TX_DATA: begin
                if (r_tx_timer == BIT_LAST) begin
                    w_tx_timer_nx = '0;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nx = TX_STOP;
                        w_txd_nx      = 1'b1;
                    end else begin
                        w_tx_bit_nx   = r_tx_bit + 3'd1;
                        w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
                        w_txd_nx      = r_tx_shift[1];
                    end
                end else begin
                    w_tx_timer_nx = r_tx_timer + TW'(1);
                end
            end
            TX_STOP: begin
                if (r_tx_timer == BIT_LAST) begin
                    w_tx_timer_nx = '0;
                    w_tx_state_nx = TX_IDLE;
                    // A byte already waiting starts straight after the stop bit.
                    w_tx_load     = r_tx_full;
                end else begin
                    w_tx_timer_nx = r_tx_timer + TW'(1);
                end
            end
            default: w_tx_state_nx = TX_IDLE;
        endcase
        if (w_tx_load) begin
            w_tx_shift_nx = r_tx_hold;
            w_tx_state_nx = TX_START;
            w_tx_timer_nx = '0;
            w_txd_nx      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_timer <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
            r_tx_hold  <= '0;
            r_tx_full  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_timer <= w_tx_timer_nx;
            r_tx_bit   <= w_tx_bit_nx;
            r_tx_shift <= w_tx_shift_nx;
            r_txd      <= w_txd_nx;
            if (w_wr_data && !r_tx_full) r_tx_hold <= data_in;
            if (w_tx_load)      r_tx_full <= 1'b0;
            else if (w_wr_data) r_tx_full <= 1'b1;
        end
    end

    assign txd = r_txd;

    // ---------------- receive ----------------
    rx_state_t r_rx_state, w_rx_state_nx;
    logic [TW-1:0] r_rx_timer, w_rx_timer_nx;
    logic [2:0] r_rx_bit, w_rx_bit_nx;
    logic [7:0] r_rx_shift, w_rx_shift_nx;
    logic r_rx_s1, r_rx_s2;

    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_timer_nx = r_rx_timer;
        w_rx_bit_nx   = r_rx_bit;
        w_rx_shift_nx = r_rx_shift;
        w_push        = 1'b0;
        w_ferr_set    = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_timer_nx = '0;
                if (!r_rx_s2) w_rx_state_nx = RX_START;
            end
            RX_START: begin
                if (r_rx_timer == HALF_LAST) begin
                    w_rx_timer_nx = '0;
                    w_rx_bit_nx   = '0;
                    w_rx_state_nx = r_rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    w_rx_timer_nx = r_rx_timer + TW'(1);
                end
            end
            RX_DATA: begin
                if (r_rx_timer == BIT_LAST) begin
                    w_rx_timer_nx = '0;
                    w_rx_shift_nx = {r_rx_s2, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) w_rx_state_nx = RX_STOP;
                    else                  w_rx_bit_nx   = r_rx_bit + 3'd1;
                end else begin
                    w_rx_timer_nx = r_rx_timer + TW'(1);
                end
            end
            RX_STOP: begin
                if (r_rx_timer == BIT_LAST) begin
                    w_rx_timer_nx = '0;
                    w_push        = r_rx_s2;
                    w_ferr_set    = ~r_rx_s2;
                    w_rx_state_nx = r_rx_s2 ? RX_IDLE : RX_BREAK;
                end else begin
                    w_rx_timer_nx = r_rx_timer + TW'(1);
                end
            end
            RX_BREAK: if (r_rx_s2) w_rx_state_nx = RX_IDLE;
            default:  w_rx_state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_timer <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_ovr      <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_rx_s1    <= rxd;
            r_rx_s2    <= r_rx_s1;
            r_rx_state <= w_rx_state_nx;
            r_rx_timer <= w_rx_timer_nx;
            r_rx_bit   <= w_rx_bit_nx;
            r_rx_shift <= w_rx_shift_nx;
            // A new error in the same cycle as a status read is kept, not lost.
            if (w_ovr_set)      r_ovr <= 1'b1;
            else if (w_rd_stat) r_ovr <= 1'b0;
            if (w_ferr_set)     r_ferr <= 1'b1;
            else if (w_rd_stat) r_ferr <= 1'b0;
        end
    end

`ifdef MUX_UART_RXFIFO_EN
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    logic [7:0] r_mem [RX_FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0] r_cnt;
    logic w_rx_full, w_push_ok;

    assign w_rx_avail = (r_cnt != '0);
    assign w_rx_full  = (r_cnt == (AW+1)'(RX_FIFO_DEPTH));
    assign w_pop      = w_rd_data & w_rx_avail;
    assign w_push_ok  = w_push & (~w_rx_full | w_pop);
    assign w_ovr_set  = w_push & w_rx_full & ~w_pop;
    assign w_rx_head  = w_rx_avail ? r_mem[r_rp] : 8'h00;

    always_ff @(posedge clock) begin
        if (w_push_ok) r_mem[r_wp] <= r_rx_shift;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push_ok) r_wp <= r_wp + AW'(1);
            if (w_pop)     r_rp <= r_rp + AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
`else
    logic [7:0] r_rx_hold;
    logic r_rx_avail, w_push_ok;

    assign w_rx_avail = r_rx_avail;
    assign w_pop      = w_rd_data & r_rx_avail;
    assign w_push_ok  = w_push & (~r_rx_avail | w_pop);
    assign w_ovr_set  = w_push & r_rx_avail & ~w_pop;
    assign w_rx_head  = r_rx_avail ? r_rx_hold : 8'h00;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_hold  <= '0;
            r_rx_avail <= 1'b0;
        end else if (w_push_ok) begin
            r_rx_hold  <= r_rx_shift;
            r_rx_avail <= 1'b1;
        end else if (w_pop) begin
            r_rx_avail <= 1'b0;
        end
    end
`endif

    assign w_status = {4'b0000, r_ferr, r_ovr, ~r_tx_full, w_rx_avail};

    always_comb begin
        data_out = 8'h00;
        if (w_sel_stat)      data_out = w_status;
        else if (w_sel_data) data_out = w_rx_head;
    end

    assign o_dbg_tx_state = r_tx_state;
    assign o_dbg_rx_state = r_rx_state;
endmodule

// File: tb/tb_mux_uart.sv
// Randomised bench for mux_uart: bit-level txd frame checks, loopback and driven rxd against a queue model.
module tb_mux_uart;
    localparam int CPB = 16;
    localparam logic [15:0] A_STAT = 16'hF200;
    localparam logic [15:0] A_DATA = 16'hF201;
`ifdef MUX_UART_RXFIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [15:0] address = '0;
    logic write_en = 1'b0, read_en = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic sel, txd, rxd;
    logic [1:0] dbg_tx;
    logic [2:0] dbg_rx;
    logic r_loop = 1'b0;
    logic tb_rxd = 1'b1;

    always #5 clock = ~clock;
    assign rxd = r_loop ? txd : tb_rxd;

    mux_uart dut (
        .clock(clock), .reset(reset), .address(address), .write_en(write_en),
        .read_en(read_en), .data_in(data_in), .data_out(data_out), .sel(sel),
        .txd(txd), .rxd(rxd), .o_dbg_tx_state(dbg_tx), .o_dbg_rx_state(dbg_rx)
    );

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];
    bit exp_ovr  = 1'b0;
    bit exp_ferr = 1'b0;
    logic [7:0] burst [8];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic void model_push(input logic [7:0] b);
        if (exp_q.size() < CAP) exp_q.push_back(b);
        else exp_ovr = 1'b1;
    endfunction

    function automatic logic [7:0] model_status(input bit tx_ready);
        return {4'b0000, exp_ferr, exp_ovr, tx_ready, exp_q.size() != 0};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clock);
        address = a; data_in = d; write_en = 1'b1; read_en = 1'b0;
        @(negedge clock);
        write_en = 1'b0;
    endtask

    task automatic peek(input logic [15:0] a, output logic [7:0] v);
        address = a; write_en = 1'b0; read_en = 1'b0;
        #1 v = data_out;
    endtask

    task automatic check_status(input string tag);
        logic [7:0] v;
        peek(A_STAT, v);
        check(tag, v, model_status(1'b1));
    endtask

    task automatic read_status(input string tag);
        @(negedge clock);
        address = A_STAT; read_en = 1'b1;
        #1 check(tag, data_out, model_status(1'b1));
        @(negedge clock);
        read_en = 1'b0;
        exp_ovr = 1'b0;
        exp_ferr = 1'b0;
    endtask

    task automatic read_data(input string tag);
        logic [7:0] e;
        e = 8'h00;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        @(negedge clock);
        address = A_DATA; read_en = 1'b1;
        #1 check(tag, data_out, e);
        @(negedge clock);
        read_en = 1'b0;
    endtask

    // Entered on the falling clock edge just after txd should have dropped for the start bit.
    task automatic expect_tx_frame(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        check("txd_start_edge", 8'(txd), 8'h00);
        repeat (CPB / 2 - 1) @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("txd_bit%0d", i), 8'(txd), 8'(fr[i]));
            repeat (i == 9 ? CPB / 2 + 1 : CPB) @(negedge clock);
        end
    endtask

    task automatic tx_send(input logic [7:0] b);
        logic [7:0] v;
        bus_write(A_DATA, b);
        peek(A_STAT, v);
        check("status_busy", v, model_status(1'b0));
        @(negedge clock);
        peek(A_STAT, v);
        check("status_ready", v, model_status(1'b1));
        expect_tx_frame(b);
    endtask

    // Writes burst[0..n-1] so each one lands while its predecessor is on the wire.
    task automatic send_burst(input int n, input bit extra);
        bus_write(A_DATA, burst[0]);
        @(negedge clock);
        fork
            for (int k = 0; k < n; k++) expect_tx_frame(burst[k]);
            begin
                for (int k = 1; k < n; k++) begin
                    repeat (k == 1 ? 28 : 10 * CPB - 2) @(negedge clock);
                    bus_write(A_DATA, burst[k]);
                end
                if (extra) bus_write(A_DATA, 8'hEE);
            end
        join
        check("txd_idle_after_burst", 8'(txd), 8'h01);
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            tb_rxd = fr[i];
            repeat (CPB) @(negedge clock);
        end
        tb_rxd = 1'b1;
        repeat (2 * CPB) @(negedge clock);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] v, b;
        repeat (4) @(negedge clock);
        check("txd_in_reset", 8'(txd), 8'h01);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        check_status("reset_status");
        check("sel_status", 8'(sel), 8'h01);
        read_data("reset_data");
        check("txd_reset", 8'(txd), 8'h01);
        peek(16'h1234, v);
        check("unmapped_data", v, 8'h00);
        check("unmapped_sel", 8'(sel), 8'h00);

        tx_send(8'h48);
        check_status("after_48");

        r_loop = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i == 0) b = 8'h55;
            tx_send(b);
            model_push(b);
            check_status("loop_avail");
            read_data("loop_data");
            check_status("loop_after_pop");
        end

        r_loop = 1'b0;
        for (int k = 0; k < 3; k++) burst[k] = 8'($urandom_range(0, 255));
        send_burst(3, 1'b1);
        repeat (3 * CPB) @(negedge clock);
        check("txd_dropped_write", 8'(txd), 8'h01);
        check_status("after_drop");

        r_loop = 1'b1;
        for (int k = 0; k <= CAP; k++) burst[k] = 8'($urandom_range(0, 255));
        send_burst(CAP + 1, 1'b0);
        for (int k = 0; k <= CAP; k++) model_push(burst[k]);
        check_status("overrun_flag");
        read_status("overrun_read");
        check_status("overrun_cleared");
        while (exp_q.size() != 0) read_data("overrun_order");
        read_data("drained_empty");
        check_status("drained_status");

        r_loop = 1'b0;
        drive_rx(8'hA5, 1'b0);
        exp_ferr = 1'b1;
        check_status("ferr_flag");
        read_status("ferr_read");
        check_status("ferr_cleared");
        read_data("ferr_no_data");

        b = 8'($urandom_range(0, 255));
        drive_rx(b, 1'b1);
        model_push(b);
        check_status("ext_avail");
        read_data("ext_data");

        tb_rxd = 1'b0;
        repeat (3) @(negedge clock);
        tb_rxd = 1'b1;
        repeat (3 * CPB) @(negedge clock);
        check_status("glitch_ignored");

        bus_write(A_DATA, 8'h48);
        repeat (5 * CPB + 8) @(negedge clock);
        check("txd_mid_frame", 8'(txd), 8'h00);
        reset = 1'b0;
        #1 check("txd_async_reset", 8'(txd), 8'h01);
        exp_q.delete();
        exp_ovr = 1'b0;
        exp_ferr = 1'b0;
        check_status("status_in_reset");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_status("status_after_reset");
        read_data("data_after_reset");

        r_loop = 1'b1;
        b = 8'($urandom_range(0, 255));
        tx_send(b);
        model_push(b);
        read_data("recover_data");
        check_status("recover_status");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule
